// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to transmitter and receiver,
// plus frame geometry constants.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    START   = 3'b001,
    DATA    = 3'b010,
    STOP    = 3'b011,
    RECOVER = 3'b100
  } uart_state_t;

  // Cycles the receiver waits in START before confirming the start bit.
  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits MSB first, 1 stop; samples mid-bit using
// a baud counter re-centred on the detected start edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_reg;
  logic [CNT_W-1:0]     baud_cnt_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [7:0]           data_out_reg;
  logic                 data_valid_reg;
  logic                 frame_err_reg;
  logic                 busy_reg;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      data_out_reg   <= 8'h00;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt_reg <= '0;
            state_reg    <= START;
            busy_reg     <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt_reg == HALF_LAST) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_s) begin
              state_reg <= DATA;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {shift_reg[DATA_BITS-2:0], rx_s};
            bit_cnt_reg  <= bit_cnt_reg + BIT_CNT_W'(1);
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= STOP;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            if (rx_s) begin
              data_out_reg   <= shift_reg;
              data_valid_reg <= 1'b1;
              state_reg      <= IDLE;
              busy_reg       <= 1'b0;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= RECOVER;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        RECOVER: begin
          // Hold off until the line returns high so a break yields one error only.
          if (rx_s) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each driven frame queues its expected pulse,
// and a negedge monitor pops and compares when data_valid/frame_err fire.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dv_cyc = -1;
  int   prev_dv_cyc = -1;
  int   t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (data_valid && frame_err) check("dv_ferr_overlap", 32'd1, 32'd0);
      if (data_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, e.is_err});
          check("data_out", {24'd0, data_out}, {24'd0, e.data});
        end
        if (data_valid) begin
          prev_dv_cyc = dv_cyc;
          dv_cyc      = cyc;
        end
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, {24'd0, data_out}, 32'h00);
    check({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] partial;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy1", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("post_reset_busy2", {31'd0, busy}, 32'd0);
    idle(5);

    // Single good frame and its latency from the start edge.
    exp_q.push_back('{is_err: 1'b0, data: 8'hA5});
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_latency", dv_cyc - t0, 32'd155);
    check("a5_busy_after", {31'd0, busy}, 32'd0);
    check("a5_pending", exp_q.size(), 32'd0);

    // Short low glitch: start detected, then rejected at mid start bit.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_during", {31'd0, busy}, 32'd1);
    idle(30);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_pending", exp_q.size(), 32'd0);

    // Good frame, framing error, break, recovery, good frame.
    exp_q.push_back('{is_err: 1'b0, data: 8'h3C});
    send_frame(8'h3C, 1'b1);
    exp_q.push_back('{is_err: 1'b1, data: 8'h3C});
    send_frame(8'h81, 1'b0);
    repeat (100) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_pending", exp_q.size(), 32'd0);
    idle(20);
    check("recover_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back('{is_err: 1'b0, data: 8'h7E});
    send_frame(8'h7E, 1'b1);
    idle(20);
    check("7e_pending", exp_q.size(), 32'd0);

    // Reset in the middle of the 4th data bit aborts the frame silently.
    partial = 8'h5A;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 5; i--) begin
      rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    rx = partial[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    idle(30);
    check("after_reset_busy", {31'd0, busy}, 32'd0);
    check("after_reset_pending", exp_q.size(), 32'd0);
    exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("ff_pending", exp_q.size(), 32'd0);

    // Back-to-back frames with no idle gap.
    exp_q.push_back('{is_err: 1'b0, data: 8'h00});
    exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_spacing", dv_cyc - prev_dv_cyc, 32'd160);
    check("b2b_pending", exp_q.size(), 32'd0);
    check("b2b_busy_after", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
